// File: rtl/inagu_nd_pkg.sv
// inagu_nd_pkg: shared width defaults and state encodings for the MVU input/weight address generator.
package inagu_nd_pkg;
    localparam int DEF_BPREC    = 6;
    localparam int DEF_BWBANKA  = 9;
    localparam int DEF_BDBANKA  = 15;
    localparam int DEF_BWLENGTH = 8;
    localparam int DEF_NDIM     = 4;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
endpackage

// File: rtl/inagu_nd_if.sv
// inagu_nd_if: job configuration, step control and address-beat outputs of the address generator.
interface inagu_nd_if import inagu_nd_pkg::*; #(
    parameter int BPREC    = DEF_BPREC,
    parameter int BWBANKA  = DEF_BWBANKA,
    parameter int BDBANKA  = DEF_BDBANKA,
    parameter int BWLENGTH = DEF_BWLENGTH,
    parameter int NDIM     = DEF_NDIM
) ();
    logic                       start;
    logic                       en;
    logic [BPREC-1:0]           iprecision;
    logic [BPREC-1:0]           wprecision;
    logic [NDIM*BDBANKA-1:0]    istride;
    logic [NDIM*BWLENGTH-1:0]   ilength;
    logic [BDBANKA-1:0]         ibaseaddr;
    logic [NDIM*BWBANKA-1:0]    wstride;
    logic [NDIM*BWLENGTH-1:0]   wlength;
    logic [BWBANKA-1:0]         wbaseaddr;
    logic                       busy;
    logic                       valid;
    logic [BDBANKA-1:0]         iaddr_out;
    logic [BWBANKA-1:0]         waddr_out;
    logic                       imsb;
    logic                       wmsb;
    logic                       sh_out;
    logic                       shacc_done;
    logic                       done;
    modport master (
        output start, en, iprecision, wprecision, istride, ilength, ibaseaddr,
               wstride, wlength, wbaseaddr,
        input  busy, valid, iaddr_out, waddr_out, imsb, wmsb, sh_out, shacc_done, done
    );
    // wlength mirrors ilength by contract, so the generator never reads it
    modport slave (
        input  start, en, iprecision, wprecision, istride, ilength, ibaseaddr,
               wstride, wbaseaddr,
        output busy, valid, iaddr_out, waddr_out, imsb, wmsb, sh_out, shacc_done, done
    );
endinterface

// File: rtl/inagu_nd_zigzag.sv
// inagu_nd_zigzag: walks (offw, offd) bit-plane pairs diagonal by diagonal, offw ascending within a diagonal.
module inagu_nd_zigzag import inagu_nd_pkg::*; #(
    parameter int BPREC = DEF_BPREC
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             i_init,
    input  logic             i_step,
    input  logic [BPREC-1:0] i_pw,
    input  logic [BPREC-1:0] i_pd,
    output logic [BPREC-1:0] o_offw,
    output logic [BPREC-1:0] o_offd,
    output logic             o_first,
    output logic             o_last
);
    logic [BPREC:0]   r_s;
    logic [BPREC-1:0] r_offw;
    logic [BPREC:0]   w_pw1, w_pd1, w_sn, w_lo, w_lo_n, w_hi;
    assign w_pw1   = {1'b0, i_pw} - 1'b1;
    assign w_pd1   = {1'b0, i_pd} - 1'b1;
    assign w_sn    = r_s + 1'b1;
    assign w_lo    = r_s > w_pd1 ? r_s - w_pd1 : '0;
    assign w_lo_n  = w_sn > w_pd1 ? w_sn - w_pd1 : '0;
    assign w_hi    = r_s < w_pw1 ? r_s : w_pw1;
    assign o_offw  = r_offw;
    assign o_offd  = BPREC'(r_s - {1'b0, r_offw});
    assign o_first = {1'b0, r_offw} == w_lo;
    assign o_last  = r_s == w_pw1 + w_pd1;
    always_ff @(posedge clk) begin
        if (!clr_n || i_init) begin
            r_s    <= '0;
            r_offw <= '0;
        end else if (i_step) begin
            if (o_last) begin
                r_s    <= '0;
                r_offw <= '0;
            end else if ({1'b0, r_offw} == w_hi) begin
                r_s    <= w_sn;
                r_offw <= BPREC'(w_lo_n);
            end else begin
                r_offw <= r_offw + 1'b1;
            end
        end
    end
endmodule

// File: rtl/inagu_nd.sv
// inagu_nd: loop-nest address generator emitting paired data/weight addresses with zig-zag bit-plane offsets.
module inagu_nd import inagu_nd_pkg::*; #(
    parameter int BPREC    = DEF_BPREC,
    parameter int BWBANKA  = DEF_BWBANKA,
    parameter int BDBANKA  = DEF_BDBANKA,
    parameter int BWLENGTH = DEF_BWLENGTH,
    parameter int NDIM     = DEF_NDIM
) (
    input logic       clk,
    input logic       clr_n,
    inagu_nd_if.slave bus
);
    logic [0:0]          r_state;
    logic [BPREC-1:0]    r_pw, r_pd;
    logic [BDBANKA-1:0]  r_ibase, r_iaddr;
    logic [BWBANKA-1:0]  r_wbase, r_waddr;
    logic [BDBANKA-1:0]  r_istr [NDIM];
    logic [BDBANKA-1:0]  r_iacc [NDIM];
    logic [BWBANKA-1:0]  r_wstr [NDIM];
    logic [BWBANKA-1:0]  r_wacc [NDIM];
    logic [BWLENGTH-1:0] r_len [NDIM];
    logic [BWLENGTH-1:0] r_c [NDIM];
    logic                r_valid, r_imsb, r_wmsb, r_sh, r_shacc, r_done;
    logic [NDIM-1:0]     w_inc, w_wrap;
    logic                w_start, w_beat, w_first, w_last;
    logic [BPREC-1:0]    w_offw, w_offd;
    logic [BDBANKA-1:0]  w_iaddr;
    logic [BWBANKA-1:0]  w_waddr;
    assign w_start = r_state == S_IDLE && bus.start;
    assign w_beat  = r_state == S_RUN && bus.en;
    inagu_nd_zigzag #(.BPREC(BPREC)) u_zz (
        .clk     (clk),
        .clr_n   (clr_n),
        .i_init  (w_start),
        .i_step  (w_beat && w_wrap[0]),
        .i_pw    (r_pw),
        .i_pd    (r_pd),
        .o_offw  (w_offw),
        .o_offd  (w_offd),
        .o_first (w_first),
        .o_last  (w_last)
    );
    // the zig-zag pair sits between c0 and c1, so dimension 1 only advances on a zig-zag wrap
    always_comb begin
        w_iaddr   = r_ibase + BDBANKA'(w_offd) + r_iacc[0];
        w_waddr   = r_wbase + BWBANKA'(w_offw) + r_wacc[0];
        w_inc     = '0;
        w_wrap    = '0;
        w_inc[0]  = 1'b1;
        w_wrap[0] = r_c[0] == r_len[0];
        for (int k = 1; k < NDIM; k++) begin
            w_iaddr   = w_iaddr + r_iacc[k];
            w_waddr   = w_waddr + r_wacc[k];
            w_inc[k]  = k == 1 ? w_wrap[0] && w_last : w_wrap[k-1];
            w_wrap[k] = w_inc[k] && r_c[k] == r_len[k];
        end
    end
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
            r_pw    <= '0;
            r_pd    <= '0;
            r_ibase <= '0;
            r_wbase <= '0;
            r_iaddr <= '0;
            r_waddr <= '0;
            r_valid <= 1'b0;
            r_imsb  <= 1'b0;
            r_wmsb  <= 1'b0;
            r_sh    <= 1'b0;
            r_shacc <= 1'b0;
            r_done  <= 1'b0;
            for (int k = 0; k < NDIM; k++) begin
                r_istr[k] <= '0;
                r_iacc[k] <= '0;
                r_wstr[k] <= '0;
                r_wacc[k] <= '0;
                r_len[k]  <= '0;
                r_c[k]    <= '0;
            end
        end else begin
            r_valid <= w_beat;
            r_imsb  <= w_beat && w_offd == '0;
            r_wmsb  <= w_beat && w_offw == '0;
            // any pair other than (0,0) lies on a diagonal s>0
            r_sh    <= w_beat && r_c[0] == '0 && w_first && (w_offw != '0 || w_offd != '0);
            r_shacc <= w_beat && w_wrap[0] && w_last;
            r_done  <= w_beat && w_wrap[NDIM-1];
            if (w_beat) begin
                r_iaddr <= w_iaddr;
                r_waddr <= w_waddr;
            end
            if (w_start) begin
                r_state <= S_RUN;
                r_pw    <= bus.wprecision == '0 ? BPREC'(1) : bus.wprecision;
                r_pd    <= bus.iprecision == '0 ? BPREC'(1) : bus.iprecision;
                r_ibase <= bus.ibaseaddr;
                r_wbase <= bus.wbaseaddr;
                for (int k = 0; k < NDIM; k++) begin
                    r_istr[k] <= bus.istride[k*BDBANKA +: BDBANKA];
                    r_wstr[k] <= bus.wstride[k*BWBANKA +: BWBANKA];
                    r_len[k]  <= bus.ilength[k*BWLENGTH +: BWLENGTH];
                    r_iacc[k] <= '0;
                    r_wacc[k] <= '0;
                    r_c[k]    <= '0;
                end
            end else if (w_beat) begin
                for (int k = 0; k < NDIM; k++) begin
                    if (w_inc[k]) begin
                        r_c[k]    <= w_wrap[k] ? '0 : r_c[k] + 1'b1;
                        r_iacc[k] <= w_wrap[k] ? '0 : r_iacc[k] + r_istr[k];
                        r_wacc[k] <= w_wrap[k] ? '0 : r_wacc[k] + r_wstr[k];
                    end
                end
                if (w_wrap[NDIM-1]) r_state <= S_IDLE;
            end
        end
    end
    assign bus.busy       = r_state == S_RUN;
    assign bus.valid      = r_valid;
    assign bus.iaddr_out  = r_iaddr;
    assign bus.waddr_out  = r_waddr;
    assign bus.imsb       = r_imsb;
    assign bus.wmsb       = r_wmsb;
    assign bus.sh_out     = r_sh;
    assign bus.shacc_done = r_shacc;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_inagu_nd.sv
// tb_inagu_nd: directed and randomized jobs on NDIM=4 and NDIM=2 builds, checked against a loop-nest beat model.
module tb_inagu_nd;
    typedef struct packed {
        logic [14:0] ia;
        logic [8:0]  wa;
        logic        im, wm, sh, sa, dn;
    } beat_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    inagu_nd_if #(.NDIM(4)) bus ();
    inagu_nd_if #(.NDIM(2)) bus2 ();
    inagu_nd #(.NDIM(4)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));
    inagu_nd #(.NDIM(2)) dut2 (.clk(clk), .clr_n(clr_n), .bus(bus2));

    logic [30:0] raw1, raw2, obs1, obs2;
    assign raw1 = {bus.valid, bus.busy, bus.iaddr_out, bus.waddr_out, bus.imsb, bus.wmsb,
                   bus.sh_out, bus.shacc_done, bus.done};
    assign raw2 = {bus2.valid, bus2.busy, bus2.iaddr_out, bus2.waddr_out, bus2.imsb, bus2.wmsb,
                   bus2.sh_out, bus2.shacc_done, bus2.done};
    // beat fields only mean something while valid is high
    assign obs1 = {raw1[30:29], raw1[30] ? raw1[28:0] : 29'b0};
    assign obs2 = {raw2[30:29], raw2[30] ? raw2[28:0] : 29'b0};

    int errs = 0, checks = 0;
    logic [5:0] ip, wp;
    int ilen[4], istr[4], wstr[4], ib, wb;
    int en_mode, abort_at, chg_at, tot;
    bit keep_start, pre_started, chk2, last_en;
    beat_t q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply_cfg();
        bus.iprecision = ip;
        bus.wprecision = wp;
        bus.ibaseaddr  = 15'(ib);
        bus.wbaseaddr  = 9'(wb);
        for (int k = 0; k < 4; k++) begin
            bus.istride[k*15 +: 15] = 15'(istr[k]);
            bus.wstride[k*9 +: 9]   = 9'(wstr[k]);
            bus.ilength[k*8 +: 8]   = 8'(ilen[k]);
            bus.wlength[k*8 +: 8]   = 8'(ilen[k]);
        end
        bus2.iprecision = ip;
        bus2.wprecision = wp;
        bus2.ibaseaddr  = bus.ibaseaddr;
        bus2.wbaseaddr  = bus.wbaseaddr;
        bus2.istride    = bus.istride[29:0];
        bus2.wstride    = bus.wstride[17:0];
        bus2.ilength    = bus.ilength[15:0];
        bus2.wlength    = bus.wlength[15:0];
    endtask

    task automatic set_start(input bit v);
        bus.start  = v;
        bus2.start = v;
    endtask

    task automatic set_en(input bit v);
        bus.en  = v;
        bus2.en = v;
    endtask

    // expected beats straight from the loop nest: c3..c1 outer, diagonals, offw, c0 inner
    task automatic build();
        int pwe, pde, sm, lo, hi, od, ia, wa;
        beat_t b;
        q.delete();
        pwe = (wp == 0) ? 1 : int'(wp);
        pde = (ip == 0) ? 1 : int'(ip);
        sm = pwe + pde - 2;
        for (int c3 = 0; c3 <= ilen[3]; c3++)
            for (int c2 = 0; c2 <= ilen[2]; c2++)
                for (int c1 = 0; c1 <= ilen[1]; c1++)
                    for (int s = 0; s <= sm; s++) begin
                        lo = (s - (pde - 1) > 0) ? s - (pde - 1) : 0;
                        hi = (s < pwe - 1) ? s : pwe - 1;
                        for (int ow = lo; ow <= hi; ow++) begin
                            od = s - ow;
                            for (int c0 = 0; c0 <= ilen[0]; c0++) begin
                                ia = ib + c0*istr[0] + c1*istr[1] + c2*istr[2] + c3*istr[3] + od;
                                wa = wb + c0*wstr[0] + c1*wstr[1] + c2*wstr[2] + c3*wstr[3] + ow;
                                b.ia = 15'(ia);
                                b.wa = 9'(wa);
                                b.im = od == 0;
                                b.wm = ow == 0;
                                b.sh = c0 == 0 && s > 0 && ow == lo;
                                b.sa = c0 == ilen[0] && s == sm;
                                b.dn = 1'b0;
                                q.push_back(b);
                            end
                        end
                    end
        b = q.pop_back();
        b.dn = 1'b1;
        q.push_back(b);
        tot = q.size();
        chk2 = ilen[2] == 0 && ilen[3] == 0;
    endtask

    task automatic run_job();
        beat_t b;
        bit ev, fin;
        int nb;
        build();
        apply_cfg();
        if (!pre_started) begin
            @(negedge clk);
            set_start(1'b1);
        end
        last_en = 1'b0;
        nb = 0;
        fin = 1'b0;
        for (int i = 1; i <= 5000 && !fin; i++) begin
            @(negedge clk);
            ev = i >= 2 && last_en;
            b = '0;
            if (ev) begin
                if (q.size() == 0) begin
                    chk("beat count", nb + 1, tot);
                    return;
                end
                b = q.pop_front();
                nb++;
            end
            chk("beat", obs1, {ev, !b.dn, b});
            if (chk2) chk("ndim2 beat", obs2, {ev, !b.dn, b});
            if (ev && b.dn) begin
                fin = 1'b1;
            end else if (ev && nb == abort_at) begin
                clr_n = 1'b0;
                @(negedge clk);
                clr_n = 1'b1;
                chk("abort outputs", raw1, 0);
                chk("abort outputs ndim2", raw2, 0);
                return;
            end else begin
                if (ev && nb == chg_at) begin
                    ib = ib + 'h123;
                    apply_cfg();
                end
                last_en = en_mode == 0 ? 1'b1 : en_mode == 1 ? bit'(i % 2 == 1) : bit'($urandom_range(0, 1));
                set_en(last_en);
                set_start(keep_start);
            end
        end
        chk("job finished", fin, 1);
        chk("beats issued", nb, tot);
    endtask

    task automatic cfg_clear();
        for (int k = 0; k < 4; k++) begin
            ilen[k] = 0;
            istr[k] = 0;
            wstr[k] = 0;
        end
        ib = 0;
        wb = 0;
        en_mode = 0;
        abort_at = 0;
        chg_at = 0;
        keep_start = 1'b0;
        pre_started = 1'b0;
    endtask

    initial begin
        cfg_clear();
        ip = 6'd1;
        wp = 6'd1;
        apply_cfg();
        set_start(1'b0);
        set_en(1'b0);
        repeat (2) @(negedge clk);
        chk("reset outputs", raw1, 0);
        chk("reset outputs ndim2", raw2, 0);
        clr_n = 1'b1;
        // 2x2 zig-zag over two c0 iterations
        ip = 6'd2; wp = 6'd2; ilen[0] = 1; istr[0] = 2; wstr[0] = 2;
        run_job();
        // data address wrap across dimension 1, precision 0 read as 1
        cfg_clear();
        ip = 6'd0; wp = 6'd1; ilen[0] = 3; ilen[1] = 1; istr[0] = 1; istr[1] = 16; ib = 'h7FFE;
        wstr[0] = 3; wstr[1] = 40; wb = 'h1F0;
        run_job();
        en_mode = 1;
        run_job();
        // start held through a job, base changed mid-job, back-to-back second job
        en_mode = 0; keep_start = 1'b1; chg_at = 2;
        run_job();
        keep_start = 1'b0; pre_started = 1'b1; chg_at = 0;
        run_job();
        // abort at beat 3, then a clean rerun
        pre_started = 1'b0; abort_at = 3;
        run_job();
        abort_at = 0;
        run_job();
        // three weight planes, one data plane, all lengths 0
        cfg_clear();
        ip = 6'd1; wp = 6'd3; ib = 'h100; wb = 'h20;
        run_job();
        for (int t = 0; t < 6; t++) begin
            cfg_clear();
            en_mode = 2;
            ip = 6'($urandom_range(0, 4));
            wp = 6'($urandom_range(0, 4));
            ilen[0] = $urandom_range(0, 3);
            ilen[1] = $urandom_range(0, 2);
            ilen[2] = (t % 2 == 1) ? $urandom_range(0, 2) : 0;
            ilen[3] = (t % 2 == 1) ? $urandom_range(0, 1) : 0;
            for (int k = 0; k < 4; k++) begin
                istr[k] = $urandom_range(0, 32767);
                wstr[k] = $urandom_range(0, 511);
            end
            ib = $urandom_range(0, 32767);
            wb = $urandom_range(0, 511);
            run_job();
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/inagu_nd.md
Name: inagu_nd

Overview:
- Next-generation input/weight address generator for the MVU bit-serial datapath.
- Loop-nest depth is parametrised (NDIM counters), configuration is latched per job behind a start/busy/done handshake, and outputs are registered with a valid flag.
- Generates paired data-bank and weight-bank addresses plus zig-zag bit-plane offsets, accumulator shift and accumulation-done strobes for the MVP array.

Parameters:
BPREC, 6, bitwidth of precision fields
BWBANKA, 9, weight memory address width
BDBANKA, 15, data memory address width
BWLENGTH, 8, loop length field width
NDIM, 4, number of loop dimensions (>=2)

Ports:
clk  in  1  clock
clr_n  in  1  synchronous active-low reset
start  in  1  job start request, accepted only when busy=0
en  in  1  step enable; 0 stalls the loop nest
iprecision  in  BPREC  data precision (bit planes); 0 treated as 1
wprecision  in  BPREC  weight precision; 0 treated as 1
istride  in  NDIM*BDBANKA  data strides, dim k at [k*BDBANKA +: BDBANKA]
ilength  in  NDIM*BWLENGTH  data loop lengths (iterations-1), packed likewise
ibaseaddr  in  BDBANKA  data base address
wstride  in  NDIM*BWBANKA  weight strides, packed
wlength  in  NDIM*BWLENGTH  weight lengths (iterations-1); must equal ilength, data lengths govern
wbaseaddr  in  BWBANKA  weight base address
busy  out  1  job in progress
valid  out  1  address beat valid this cycle
iaddr_out  out  BDBANKA  data address
waddr_out  out  BWBANKA  weight address
imsb  out  1  data bit-plane offset is 0 (MSB)
wmsb  out  1  weight bit-plane offset is 0
sh_out  out  1  accumulator shift before this beat
shacc_done  out  1  last beat of an accumulation
done  out  1  one-cycle pulse on the final beat of a job

Behaviour:
- Reset: clr_n=0 at posedge clears all state; every output 0 the following cycle. Aborts any job in progress; no done is issued.
- States: IDLE, RUN.
  - IDLE: start=1 latches all config inputs into shadow registers, clears counters, enters RUN; busy=1 from the next cycle.
  - start while busy is ignored, including on the final-beat cycle.
- Loop order, innermost first: c0 over 0..ilength0; zig-zag pair (offw, offd); then c1..c(NDIM-1).
- Zig-zag:
  - Diagonals s = 0..pw+pd-2.
  - Within each diagonal, offw ascends from max(0, s-(pd-1)) to min(s, pw-1); offd = s-offw.
  - Offset 0 is the MSB plane.
- Each RUN cycle with en=1 issues one beat; en=0 freezes all counters and outputs valid=0.
- Addressing, computed modulo 2^width:
  - iaddr = ibase + sum_k(c_k*istride_k) + offd.
  - waddr = wbase + sum_k(c_k*wstride_k) + offw.
  - Stride terms are maintained as running accumulators; no multipliers.
- Latency: outputs are registered. A beat issued in cycle t appears in cycle t+1 with valid=1.
- Per-beat flags, all qualified by valid:
  - sh_out=1 on c0=0 of the first pair of each diagonal s>0.
  - shacc_done=1 when c0=ilength0 on the last zig-zag pair.
  - imsb = (offd==0); wmsb = (offw==0).
- Job length: beats = prod_k(ilength_k+1) * pw * pd.
  - done=1 with valid on the last beat.
  - busy drops in the same cycle done is presented.
  - A new start is accepted that cycle at the earliest.
- Boundaries:
  - pw=pd=1: one diagonal, sh_out never asserted, shacc_done every ilength0+1 beats.
  - All lengths 0: a single accumulation.
  - Counter wrap of dimension k clears c0..c(k-1) and increments c_k; the outermost wrap ends the job.

Decomposition:
- Shared package/header mvu_agu_defs:
  - Width defaults BPREC, BWBANKA, BDBANKA, BWLENGTH.
  - State encodings IDLE/RUN.
  - Packed-field slice helper macros.
- One natural sub-module: zigzag_seq. Holds the pw/pd diagonal counters; outputs offw, offd, first-of-diagonal and last-pair; steps on c0 wrap.

Test Plan:
- pw=pd=2, ilength0=1, other lengths 0, istride0=wstride0=2, bases 0 -> 8 beats, one per cycle:
  - iaddr 0,2,1,3,0,2,1,3; waddr 0,2,0,2,1,3,1,3.
  - sh_out on beats 3 and 7; imsb on beats 1,2,5,6.
  - shacc_done and done on beat 8; busy low the same cycle.
- pw=pd=1, ilength0=3, ilength1=1, istride1=16, ibase=0x7FFE (BDBANKA=15) with istride0=1 -> iaddr 7FFE,7FFF,0000,0001, then 000E,000F,0010,0011 (wrap modulo 2^15); shacc_done on beats 4 and 8; done on beat 8.
- Same job with en toggling 1,0,1,0 -> address sequence unchanged, valid only after en=1 cycles, counters frozen during en=0.
- start held high through the whole job; change ibaseaddr mid-job -> addresses use the latched base; the second job starts the cycle busy drops.
- clr_n=0 at beat 3 -> all outputs 0 the next cycle, no done; a fresh start then yields the full sequence from beat 1.
- NDIM=2 parameter build, pw=3, pd=1, all lengths 0 -> 3 beats with offw 0,1,2, offd 0, sh_out on beats 2,3, wmsb on beat 1 only.
